// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared constants and helpers for stream_demux
//
// Purpose: holds the SoC-wide drop counter width, its saturation value and a
//          saturating increment helper used by the demux top.
// Ports:   none (package).
package stream_demux_pkg;

  localparam int unsigned DROP_CNT_W = 16;

  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

  localparam drop_cnt_t DROP_CNT_MAX = '1;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic drop_cnt_t sat_inc(input drop_cnt_t cnt);
    return (cnt == DROP_CNT_MAX) ? cnt : cnt + drop_cnt_t'(1);
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// rtl/stream_reg_slice.sv - single-entry valid/ready register slice
//
// Purpose: one output slot of the demux. Holds at most one beat; accepts a new
//          beat when empty or when the held beat leaves in the same cycle.
// Ports:   clk_i, rst_ni   - clock, asynchronous active-low reset
//          s_data_i/s_valid_i/s_ready_o - upstream side
//          m_data_o/m_valid_o/m_ready_i - downstream side
module stream_reg_slice #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load;

  // Empty, or full but draining this cycle: the refill path keeps a
  // continuously-ready consumer at full throughput.
  assign s_ready_o = ~valid_q | m_ready_i;

  always_comb begin
    load    = s_valid_i & s_ready_o;
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = s_data_i;
    end else if (m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - 1-to-N stream demultiplexer with per-output slots
//
// Purpose: routes each input beat to the output slot named by sel_i. Every
//          output has its own register slice, so a stalled output never
//          blocks the others. Out-of-range selects are accepted and discarded,
//          flagged on err_o and counted in a saturating drop counter.
// Ports:   clk_i, rst_ni              - clock, asynchronous active-low reset
//          data_i/sel_i/valid_i/ready_o - input stream with destination index
//          data_o/valid_o/ready_i     - N_OUTPUTS packed output streams
//          err_o                      - one-cycle pulse per discarded beat
//          drop_cnt_o                 - saturating count of discarded beats
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned N_OUTPUTS = 4,
  localparam int unsigned SEL_W     = $clog2(N_OUTPUTS)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [WIDTH-1:0]           data_i,
  input  logic [SEL_W-1:0]           sel_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [N_OUTPUTS*WIDTH-1:0] data_o,
  output logic [N_OUTPUTS-1:0]       valid_o,
  input  logic [N_OUTPUTS-1:0]       ready_i,
  output logic                       err_o,
  output logic [DROP_CNT_W-1:0]      drop_cnt_o
);

  // run_q holds ready_o low until the first clock edge after reset release.
  logic                 run_q, run_d;
  logic                 err_q, err_d;
  drop_cnt_t            drop_cnt_q, drop_cnt_d;

  logic [N_OUTPUTS-1:0] slot_ready;
  logic [N_OUTPUTS-1:0] slot_load;
  logic                 sel_in_range;
  logic                 sel_ready;
  logic                 accept;

  // Select decode. Compared at 32 bits so the range check stays meaningful
  // for both power-of-two and non-power-of-two output counts.
  always_comb begin
    sel_in_range = (32'(sel_i) < N_OUTPUTS);
    sel_ready    = 1'b0;
    for (int k = 0; k < int'(N_OUTPUTS); k++) begin
      if (sel_i == SEL_W'(k)) begin
        sel_ready = slot_ready[k];
      end
    end
    // Depends only on sel_i and slot state, never on valid_i.
    ready_o = run_q & (~sel_in_range | sel_ready);
    accept  = valid_i & ready_o;
    slot_load = '0;
    for (int k = 0; k < int'(N_OUTPUTS); k++) begin
      slot_load[k] = accept & sel_in_range & (sel_i == SEL_W'(k));
    end
  end

  always_comb begin
    run_d      = 1'b1;
    err_d      = accept & ~sel_in_range;
    drop_cnt_d = drop_cnt_q;
    if (err_d) begin
      drop_cnt_d = sat_inc(drop_cnt_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q      <= 1'b0;
      err_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      run_q      <= run_d;
      err_q      <= err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign err_o      = err_q;
  assign drop_cnt_o = drop_cnt_q;

  for (genvar k = 0; k < N_OUTPUTS; k++) begin : g_slot
    stream_reg_slice #(
      .WIDTH (WIDTH)
    ) u_slice (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .s_data_i  (data_i),
      .s_valid_i (slot_load[k]),
      .s_ready_o (slot_ready[k]),
      .m_data_o  (data_o[k*WIDTH +: WIDTH]),
      .m_valid_o (valid_o[k]),
      .m_ready_i (ready_i[k])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - self-checking bench for stream_demux
module tb_stream_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Four-output instance: routing, backpressure, independence, reset.
  logic        rst4_n;
  logic [7:0]  d4_data;
  logic [1:0]  d4_sel;
  logic        d4_valid;
  logic        d4_ready_o;
  logic [31:0] d4_data_o;
  logic [3:0]  d4_valid_o;
  logic [3:0]  d4_rdy;
  logic        d4_err;
  logic [15:0] d4_drop;

  // Three-output instance: out-of-range selects, random run, saturation.
  logic        rst3_n;
  logic [7:0]  d3_data;
  logic [1:0]  d3_sel;
  logic        d3_valid;
  logic        d3_ready_o;
  logic [23:0] d3_data_o;
  logic [2:0]  d3_valid_o;
  logic [2:0]  d3_rdy;
  logic        d3_err;
  logic [15:0] d3_drop;

  stream_demux #(.WIDTH(8), .N_OUTPUTS(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst4_n), .data_i(d4_data), .sel_i(d4_sel),
    .valid_i(d4_valid), .ready_o(d4_ready_o), .data_o(d4_data_o),
    .valid_o(d4_valid_o), .ready_i(d4_rdy), .err_o(d4_err), .drop_cnt_o(d4_drop)
  );

  stream_demux #(.WIDTH(8), .N_OUTPUTS(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst3_n), .data_i(d3_data), .sel_i(d3_sel),
    .valid_i(d3_valid), .ready_o(d3_ready_o), .data_o(d3_data_o),
    .valid_o(d3_valid_o), .ready_i(d3_rdy), .err_o(d3_err), .drop_cnt_o(d3_drop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] v);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (v[k]) m[k*8 +: 8] = 8'hFF;
    return m;
  endfunction

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [3:0]  rdy;
    logic        exp_ready;
    logic [3:0]  exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[13];

  // Reference model for the three-output instance: one capacity-1 queue per
  // output plus a running total of discarded beats.
  logic [7:0] mq[3][$];
  int         m_drops;

  initial begin
    logic       in_range, exp_rdy, acc, exp_err;
    logic [2:0] exp_v;
    int         n;

    // routing
    vecs[0]  = '{1'b1, 2'd0, 8'hAA, 4'hF, 1'b1, 4'b0001, 32'h000000AA};
    vecs[1]  = '{1'b1, 2'd1, 8'hBB, 4'hF, 1'b1, 4'b0010, 32'h0000BB00};
    vecs[2]  = '{1'b1, 2'd2, 8'hCC, 4'hF, 1'b1, 4'b0100, 32'h00CC0000};
    vecs[3]  = '{1'b1, 2'd3, 8'hDD, 4'hF, 1'b1, 4'b1000, 32'hDD000000};
    vecs[4]  = '{1'b0, 2'd0, 8'h5A, 4'hF, 1'b1, 4'b0000, 32'h00000000};
    // backpressure on output 2, then pass-through refill on release
    vecs[5]  = '{1'b1, 2'd2, 8'h11, 4'hB, 1'b1, 4'b0100, 32'h00110000};
    vecs[6]  = '{1'b1, 2'd2, 8'h22, 4'hB, 1'b0, 4'b0100, 32'h00110000};
    vecs[7]  = '{1'b1, 2'd2, 8'h22, 4'hF, 1'b1, 4'b0100, 32'h00220000};
    vecs[8]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h00000000};
    // output 1 stalled full, output 0 still served
    vecs[9]  = '{1'b1, 2'd1, 8'h55, 4'hD, 1'b1, 4'b0010, 32'h00005500};
    vecs[10] = '{1'b1, 2'd0, 8'h33, 4'hD, 1'b1, 4'b0011, 32'h00005533};
    vecs[11] = '{1'b1, 2'd1, 8'h66, 4'hD, 1'b0, 4'b0010, 32'h00005500};
    vecs[12] = '{1'b0, 2'd1, 8'h77, 4'hF, 1'b1, 4'b0000, 32'h00000000};

    rst4_n = 1'b0; rst3_n = 1'b0;
    d4_data = '0; d4_sel = '0; d4_valid = 1'b0; d4_rdy = '0;
    d3_data = '0; d3_sel = '0; d3_valid = 1'b0; d3_rdy = '0;
    repeat (3) @(posedge clk);
    #3;
    check("reset valid_o", 64'(d4_valid_o), 64'h0);
    check("reset data_o", 64'(d4_data_o), 64'h0);
    check("reset err_o", 64'(d4_err), 64'h0);
    check("reset drop_cnt_o", 64'(d4_drop), 64'h0);
    check("reset ready_o", 64'(d4_ready_o), 64'h0);
    check("reset ready_o n3", 64'(d3_ready_o), 64'h0);
    rst4_n = 1'b1; rst3_n = 1'b1;
    #1;
    check("ready_o before first edge", 64'(d4_ready_o), 64'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      d4_valid = vecs[i].v;
      d4_sel   = vecs[i].sel;
      d4_data  = vecs[i].data;
      d4_rdy   = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d ready_o", i), 64'(d4_ready_o), 64'(vecs[i].exp_ready));
      @(posedge clk); #1;
      check($sformatf("vec%0d valid_o", i), 64'(d4_valid_o), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d data_o", i),
            64'(d4_data_o & lane_mask(vecs[i].exp_valid)), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d err_o", i), 64'(d4_err), 64'h0);
    end
    check("n4 drop_cnt_o", 64'(d4_drop), 64'h0);

    // Reset with outputs 0 and 3 holding beats.
    d4_rdy = 4'b0110; d4_valid = 1'b1; d4_sel = 2'd0; d4_data = 8'hEE;
    @(posedge clk); #1;
    d4_sel = 2'd3; d4_data = 8'h99;
    @(posedge clk); #1;
    check("pre-reset valid_o", 64'(d4_valid_o), 64'h9);
    d4_sel = 2'd1; d4_data = 8'h12;
    #2;
    rst4_n = 1'b0;
    #1;
    check("async reset valid_o", 64'(d4_valid_o), 64'h0);
    check("async reset data_o", 64'(d4_data_o), 64'h0);
    check("async reset ready_o", 64'(d4_ready_o), 64'h0);
    @(posedge clk); #1;
    check("in reset ready_o", 64'(d4_ready_o), 64'h0);
    check("in reset valid_o", 64'(d4_valid_o), 64'h0);
    #2;
    rst4_n = 1'b1; d4_valid = 1'b0;
    #1;
    check("release ready_o pre-edge", 64'(d4_ready_o), 64'h0);
    @(posedge clk); #1;
    check("release ready_o post-edge", 64'(d4_ready_o), 64'h1);
    d4_rdy = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("no replay valid_o c%0d", c), 64'(d4_valid_o), 64'h0);
    end

    // Out-of-range select on the three-output instance.
    d3_valid = 1'b1; d3_sel = 2'd3; d3_data = 8'h44; d3_rdy = 3'b111;
    #1;
    check("oor ready_o", 64'(d3_ready_o), 64'h1);
    @(posedge clk); #1;
    d3_valid = 1'b0;
    check("oor err_o", 64'(d3_err), 64'h1);
    check("oor drop_cnt_o", 64'(d3_drop), 64'h1);
    check("oor valid_o", 64'(d3_valid_o), 64'h0);
    @(posedge clk); #1;
    check("oor err_o single pulse", 64'(d3_err), 64'h0);
    check("oor drop_cnt_o hold", 64'(d3_drop), 64'h1);
    m_drops = 1;

    // Randomised traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      d3_valid = ($urandom_range(0, 3) != 0);
      d3_sel   = 2'($urandom_range(0, 3));
      d3_data  = 8'($urandom);
      d3_rdy   = 3'($urandom);
      #1;
      in_range = (d3_sel < 2'd3);
      exp_rdy  = 1'b1;
      if (in_range) exp_rdy = (mq[d3_sel].size() == 0) || d3_rdy[d3_sel];
      check("rand ready_o", 64'(d3_ready_o), 64'(exp_rdy));
      acc = d3_valid && exp_rdy;
      for (int k = 0; k < 3; k++)
        if (mq[k].size() > 0 && d3_rdy[k]) void'(mq[k].pop_front());
      if (acc && in_range) mq[d3_sel].push_back(d3_data);
      exp_err = acc && !in_range;
      if (exp_err) m_drops++;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) exp_v[k] = (mq[k].size() > 0);
      check("rand valid_o", 64'(d3_valid_o), 64'(exp_v));
      for (int k = 0; k < 3; k++)
        if (mq[k].size() > 0)
          check($sformatf("rand data_o[%0d]", k), 64'(d3_data_o[k*8 +: 8]), 64'(mq[k][0]));
      check("rand err_o", 64'(d3_err), 64'(exp_err));
      check("rand drop_cnt_o", 64'(d3_drop),
            (m_drops > 65535) ? 64'hFFFF : 64'(m_drops));
    end

    // Drive drops up to and past the counter ceiling.
    d3_valid = 1'b1; d3_sel = 2'd3; d3_rdy = 3'b111;
    n = 65534 - m_drops;
    repeat (n) @(posedge clk);
    m_drops += n;
    #1;
    check("sat drop_cnt_o 65534", 64'(d3_drop), 64'hFFFE);
    @(posedge clk); #1;
    check("sat drop_cnt_o 65535", 64'(d3_drop), 64'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    check("sat drop_cnt_o held", 64'(d3_drop), 64'hFFFF);
    check("sat err_o", 64'(d3_err), 64'h1);
    d3_valid = 1'b0;
    @(posedge clk); #1;
    check("sat err_o idle", 64'(d3_err), 64'h0);
    check("sat drop_cnt_o idle", 64'(d3_drop), 64'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, payload width in bits.
REQ-002 SHALL have parameter N_OUTPUTS, default 4, number of output ports (>=2, need not be a power of two).
REQ-003 SHALL define localparam SEL_W = $clog2(N_OUTPUTS).
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port data_i, input, WIDTH bits, input payload.
REQ-007 SHALL have port sel_i, input, SEL_W bits, destination index, qualified by valid_i.
REQ-008 SHALL have port valid_i, input, 1 bit, input beat valid.
REQ-009 SHALL have port ready_o, output, 1 bit, input beat accepted when valid_i && ready_o.
REQ-010 SHALL have port data_o, output, N_OUTPUTS*WIDTH bits; output k occupies data_o[k*WIDTH +: WIDTH].
REQ-011 SHALL have port valid_o, output, N_OUTPUTS bits, per-output valid.
REQ-012 SHALL have port ready_i, input, N_OUTPUTS bits, per-output ready.
REQ-013 SHALL have port err_o, output, 1 bit, one-cycle pulse on out-of-range select.
REQ-014 SHALL have port drop_cnt_o, output, 16 bits, count of discarded beats.

Function
REQ-015 SHALL hold one single-entry register slot per output (data + valid).
REQ-016 SHALL accept a beat into slot k when sel_i==k and slot k is empty, or when slot k is full and ready_i[k] is high in the same cycle (pass-through refill).
REQ-017 SHALL drive ready_o combinationally from the slot addressed by sel_i; there is no combinational path from valid_i to ready_o.
REQ-018 SHALL present an accepted beat on valid_o[k] and data_o slot k exactly 1 cycle after acceptance.
REQ-019 SHALL clear valid_o[k] after handshake valid_o[k] && ready_i[k] unless a refill happens in the same cycle.
REQ-020 SHALL hold data_o slot k stable while valid_o[k] is high and ready_i[k] is low.
REQ-021 SHALL not let a stalled output block beats addressed to other outputs; each slot is independent.
REQ-022 SHALL, for sel_i >= N_OUTPUTS, assert ready_o, discard the beat, pulse err_o for 1 cycle after acceptance, and increment drop_cnt_o.
REQ-023 SHALL saturate drop_cnt_o at 16'hFFFF; it never wraps.
REQ-024 SHALL, when valid_i is low, ignore data_i and sel_i and change no slot.

Reset
REQ-025 SHALL, when rst_ni is low, asynchronously clear valid_o to 0, err_o to 0, drop_cnt_o to 0, and data_o to 0.
REQ-026 SHALL drop any buffered beats when reset is asserted mid-operation, and SHALL NOT replay them after reset.
REQ-027 SHALL keep ready_o low while rst_ni is low and leave reset on the first rising edge after rst_ni goes high.

Structure
REQ-028 SHALL take the DROP_CNT_W=16 constant from the shared SoC package.
REQ-029 SHALL implement each output slot as the sub-module stream_reg_slice (WIDTH-parameterised, valid/ready in and out), instantiated N_OUTPUTS times by a generate loop.
REQ-030 SHALL keep the select decode and drop counter in the top module; RTL target is 150-300 lines.

Verification (WIDTH=8, N_OUTPUTS=4 unless stated)
REQ-031 SHALL cover routing: beats 8'hAA..8'hDD with sel 0..3, all ready_i=1 -> each value on its own slot 1 cycle later, valid_o one-hot.
REQ-032 SHALL cover backpressure: ready_i[2]=0, send 8'h11 to sel 2 then 8'h22 to sel 2 -> ready_o low on the second beat, 8'h11 held; raise ready_i[2] -> 8'h11 then 8'h22 delivered, no loss or duplication.
REQ-033 SHALL cover independence: slot 1 stalled full, beat 8'h33 to sel 0 -> accepted same cycle, valid_o[0] next cycle.
REQ-034 SHALL cover out-of-range select with N_OUTPUTS=3: sel=3, data 8'h44 -> ready_o=1, err_o pulses once, drop_cnt_o=1, valid_o unchanged.
REQ-035 SHALL cover counter saturation: force 65536 dropped beats -> drop_cnt_o reads 16'hFFFF.
REQ-036 SHALL cover reset mid-operation: assert rst_ni low with slots 0 and 3 full -> valid_o=0 immediately, without waiting for a clock edge, and no stale beat appears after release.
